// File: rtl/asymmetric_fifo.sv
// Wide-in / narrow-out FIFO on LUT RAM; a written word is readable the cycle after its write edge.
// Writes stall while DEPTH_IN words are resident; reads stall while empty; flush clears both pointers.
module asymmetric_fifo #(
    parameter int WIDTH_IN  = 64,
    parameter int WIDTH_OUT = 8,
    parameter int DEPTH_IN  = 32,
    parameter bit MSB_FIRST = 1'b0,
    localparam int RATIO        = WIDTH_IN / WIDTH_OUT,
    localparam int LANE_W       = $clog2(RATIO),
    localparam int ADDR_A_WIDTH = $clog2(DEPTH_IN),
    localparam int ADDR_B_WIDTH = ADDR_A_WIDTH + LANE_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH_IN-1:0]   in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH_OUT-1:0]  out,
    output logic [ADDR_B_WIDTH:0] level,
    output logic                  full,
    output logic                  empty
);

    localparam logic [ADDR_A_WIDTH:0] WORDS_FULL = (ADDR_A_WIDTH+1)'(DEPTH_IN);
    localparam logic [ADDR_A_WIDTH:0] WR_INC     = (ADDR_A_WIDTH+1)'(1);
    localparam logic [ADDR_B_WIDTH:0] RD_INC     = (ADDR_B_WIDTH+1)'(1);

    logic [ADDR_A_WIDTH:0]  r_wr_ptr;
    logic [ADDR_B_WIDTH:0]  r_rd_ptr;
    logic [WIDTH_OUT-1:0]   r_mem [RATIO][DEPTH_IN];

    logic [ADDR_A_WIDTH:0]  w_rd_word;
    logic [LANE_W-1:0]      w_lane;
    logic                   w_wr_fire;
    logic                   w_rd_fire;

    assign w_rd_word = r_rd_ptr[ADDR_B_WIDTH:LANE_W];
    // RATIO is a power of two, so RATIO-1-idx is just the bitwise inverse of idx.
    assign w_lane    = MSB_FIRST ? ~r_rd_ptr[LANE_W-1:0] : r_rd_ptr[LANE_W-1:0];

    assign level     = {r_wr_ptr, {LANE_W{1'b0}}} - r_rd_ptr;
    assign full      = (r_wr_ptr - w_rd_word) == WORDS_FULL;
    assign empty     = (level == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out       = r_mem[w_lane][w_rd_word[ADDR_A_WIDTH-1:0]];

    assign w_wr_fire = in_valid & in_ready & !flush;
    assign w_rd_fire = out_valid & out_ready & !flush;

    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            for (int l = 0; l < RATIO; l++) begin
                r_mem[l][r_wr_ptr[ADDR_A_WIDTH-1:0]] <= in[l*WIDTH_OUT +: WIDTH_OUT];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_fire) r_wr_ptr <= r_wr_ptr + WR_INC;
            if (w_rd_fire) r_rd_ptr <= r_rd_ptr + RD_INC;
        end
    end

endmodule
